// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates the single write port between pipeline
// writeback and a long-latency unit, tracks LLU destinations and raises the ID issue stall.
module regfile_wb_scheduler #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // ID-stage issue
  input  logic              issue_valid,
  input  logic              issue_llu,
  input  logic [4:0]        issue_rs1,
  input  logic [4:0]        issue_rs2,
  input  logic [4:0]        issue_rd,
  output logic              issue_stall,
  // Pipeline writeback
  input  logic              pipe_wb_en,
  input  logic [4:0]        pipe_rd,
  input  logic [DATA_W-1:0] pipe_wdata,
  // Long-latency unit result
  input  logic              llu_valid,
  input  logic [4:0]        llu_rd,
  input  logic [DATA_W-1:0] llu_wdata,
  output logic              llu_ready,
  output logic              pipe_hold,
  // Register-file write port
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  // Status
  output logic [31:0]       busy_vec,
  output logic              wb_conflict
);

  localparam int unsigned CntW = $clog2(MAX_WAIT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  typedef enum logic [1:0] {StIdle, StWait, StForce} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       busy_q, busy_d;
  logic              conflict_q, conflict_d;
  logic              llu_grant;
  logic              issue_set;

  // Stall on registered busy only; x0 never becomes busy, so no special case is needed here.
  assign issue_stall = issue_valid &
                       (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);

  // The pipe always wins the port, including in FORCE when it violates the hold.
  assign llu_ready = rst_n & ~pipe_wb_en;
  assign llu_grant = llu_valid & llu_ready;
  assign pipe_hold = (state_q == StForce);

  assign issue_set = issue_valid & issue_llu & ~issue_stall & (issue_rd != 5'd0);

  // Scoreboard next state: apply clear first so a same-edge set wins.
  always_comb begin
    busy_d = busy_q;
    if (llu_grant) begin
      busy_d[llu_rd] = 1'b0;
    end
    if (issue_set) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Arbiter next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    conflict_d = conflict_q;
    unique case (state_q)
      StIdle: begin
        if (llu_valid && pipe_wb_en) begin
          state_d = StWait;
          cnt_d   = CntW'(1);
        end
      end
      StWait: begin
        if (!llu_valid || !pipe_wb_en) begin
          // Granted, or the result was withdrawn.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StForce;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StForce: begin
        if (pipe_wb_en) begin
          conflict_d = 1'b1;
        end
        if (pipe_wb_en && llu_valid) begin
          state_d = StForce;
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  // Write-port mux: pipe has priority, then a granted LLU result.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = '0;
    if (rst_n && pipe_wb_en) begin
      rf_we    = (pipe_rd != 5'd0);
      rf_waddr = pipe_rd;
      rf_wdata = pipe_wdata;
    end else if (llu_grant) begin
      rf_we    = (llu_rd != 5'd0);
      rf_waddr = llu_rd;
      rf_wdata = llu_wdata;
    end
  end

  assign busy_vec    = busy_q;
  assign wb_conflict = conflict_q;

endmodule
